// File: rtl/pio_arb_pkg.sv
// rtl/pio_arb_pkg.sv - shared types and constants for the PIO write arbiter
package pio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: lowest index at or above rr_ptr, else lowest overall
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] lo_idx;
    logic [IW-1:0] hi_idx;
    logic          hi_any;

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_any = 1'b0;
        any    = 1'b0;
        // Scan downwards so the last hit is the lowest matching index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                any    = 1'b1;
                if (IW'(i) >= rr_ptr) begin
                    hi_idx = IW'(i);
                    hi_any = 1'b1;
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
        grant     = any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// rtl/pio_write_arbiter.sv - arbitrates requester writes onto one Avalon-MM PIO data register
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [1:0]                av_address,
    output logic                      av_chipselect,
    output logic                      av_write_n,
    output logic [31:0]               av_writedata,
    input  logic                      av_waitrequest,
    output logic [DATA_W-1:0]         shadow,
    output logic                      busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win_idx;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   shadow_q;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       grant_idx;
    logic                any;
    logic                grant_fire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Gated by reset so a grant is never shown for a request that cannot be captured.
    assign grant_fire = (state == ST_IDLE) && any && !reset;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            cap_data <= '0;
            shadow_q <= '0;
        end else begin
            state <= state_nx;
            if (grant_fire) begin
                win_idx  <= grant_idx;
                cap_data <= sel_data;
                rr_ptr   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
            end
            if (state == ST_WRITE && !av_waitrequest) shadow_q <= cap_data;
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = '0;
        req_done      = '0;
        av_address    = PIO_DATA_ADDR;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_writedata  = '0;
        case (state)
            ST_IDLE: begin
                if (grant_fire) begin
                    req_ready = grant;
                    state_nx  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_writedata  = 32'(cap_data);
                if (!av_waitrequest) state_nx = ST_DONE;
            end
            ST_DONE: begin
                req_done = NUM_REQ'(1) << win_idx;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign shadow = shadow_q;
    assign busy   = (state != ST_IDLE);

endmodule
